// File: rtl/payload_checker.sv
// -----------------------------------------------------------------------------
// payload_checker
//
// Purpose:
//   Checks a received byte stream against an 8-bit incrementing sequence that
//   wraps from 0xFF to 0x00. The block has two states:
//     HUNT - the next byte seeds the expected value, and the block locks.
//     LOCK - every byte is compared against the expected value.
//   Lock is dropped after LOSS_THRESH consecutive mismatched bytes. It is also
//   dropped when GAP_MAX clk_en ticks pass without a byte strobe.
//
// Parameters:
//   LOSS_THRESH - consecutive mismatches that drop lock (1..15)
//   GAP_MAX     - clk_en ticks without dv that drop lock (1..255)
//
// Ports:
//   clk      in   system clock, rising edge
//   n_rst    in   asynchronous reset, active-low
//   clk_en   in   clock enable; all state except the counter clear waits on it
//   dv       in   byte strobe, sampled only when clk_en=1
//   d[7:0]   in   received payload byte
//   clr      in   synchronous clear of the statistics counters
//   lock     out  high while in LOCK
//   err      out  one-clk pulse per mismatched byte
//   to_err   out  one-clk pulse per gap timeout
//   err_cnt  out  saturating count of mismatched bytes
//   byte_cnt out  wrapping count of received bytes (0 unless PL_CHK_STATS_EN)
//
// Configuration:
//   PL_CHK_STATS_EN - when defined, implements the byte_cnt counter.
// -----------------------------------------------------------------------------
module payload_checker #(
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned GAP_MAX     = 40
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clk_en,
    input  logic        dv,
    input  logic [7:0]  d,
    input  logic        clr,
    output logic        lock,
    output logic        err,
    output logic        to_err,
    output logic [15:0] err_cnt,
    output logic [15:0] byte_cnt
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [3:0] LOSS_LAST = 4'(LOSS_THRESH - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_MAX - 1);

    state_t      state_q,   state_d;
    logic [7:0]  exp_q,     exp_d;
    logic [3:0]  miss_q,    miss_d;
    logic [7:0]  gap_q,     gap_d;
    logic        err_q,     err_d;
    logic        to_err_q,  to_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred. Flops use non-blocking '<='.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        miss_d    = miss_q;
        gap_d     = gap_q;
        err_d     = 1'b0;
        to_err_d  = 1'b0;
        err_cnt_d = err_cnt_q;

        if (clk_en) begin
            case (state_q)
                HUNT: begin
                    if (dv) begin
                        exp_d   = d + 8'd1;
                        miss_d  = '0;
                        gap_d   = '0;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (dv) begin
                        // A byte on the tick that would time out wins over the timeout.
                        gap_d = '0;
                        exp_d = exp_q + 8'd1;
                        if (d == exp_q) begin
                            miss_d = '0;
                        end else begin
                            err_d = 1'b1;
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_d = err_cnt_q + 16'd1;
                            end
                            if (miss_q == LOSS_LAST) begin
                                miss_d  = '0;
                                state_d = HUNT;
                            end else begin
                                miss_d = miss_q + 4'd1;
                            end
                        end
                    end else if (gap_q == GAP_LAST) begin
                        to_err_d = 1'b1;
                        gap_d    = '0;
                        state_d  = HUNT;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // The clear ignores clk_en and overrides an increment on the same edge.
        if (clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= HUNT;
            exp_q     <= '0;
            miss_q    <= '0;
            gap_q     <= '0;
            err_q     <= 1'b0;
            to_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            miss_q    <= miss_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            to_err_q  <= to_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign lock    = (state_q == LOCK);
    assign err     = err_q;
    assign to_err  = to_err_q;
    assign err_cnt = err_cnt_q;

`ifdef PL_CHK_STATS_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (clr) begin
            byte_cnt_d = '0;
        end else if (clk_en && dv) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign byte_cnt = byte_cnt_q;
`else
    assign byte_cnt = '0;
`endif

endmodule

// File: doc/payload_checker.md
PAYLOAD_CHECKER -- requirements
Module: payload_checker

Interface
REQ-001 Parameter LOSS_THRESH, default 4, is the number of consecutive mismatched bytes that drops lock (legal range 1..15).
REQ-002 Parameter GAP_MAX, default 40, is the maximum number of clk_en ticks allowed between byte strobes while locked (legal range 1..255).
REQ-003 Port clk, input, 1 bit: system clock; all logic is clocked on the rising edge.
REQ-004 Port n_rst, input, 1 bit: asynchronous reset, active-low.
REQ-005 Port clk_en, input, 1 bit: clock enable; the block advances only when clk_en is 1, except for clr.
REQ-006 Port dv, input, 1 bit: byte strobe from the decoder; it is sampled only when clk_en is 1.
REQ-007 Port d, input, 8 bits: received payload byte, valid when dv is 1.
REQ-008 Port clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-009 Port lock, output, 1 bit: high while the state is LOCK.
REQ-010 Port err, output, 1 bit: one-clk pulse on each mismatched byte.
REQ-011 Port to_err, output, 1 bit: one-clk pulse when a gap timeout occurs.
REQ-012 Port err_cnt, output, 16 bits: saturating count of mismatched bytes.
REQ-013 Port byte_cnt, output, 16 bits: count of received bytes; present only with the statistics macro.

Function
REQ-014 The source byte stream shall be an 8-bit incrementing sequence that wraps from 255 to 0, so the expected byte after 0xFF is 0x00.
REQ-015 A byte event shall be defined as clk_en=1 and dv=1 on the same rising clk edge.
REQ-016 The block shall have two states, HUNT and LOCK, with reset state HUNT.
REQ-017 In HUNT, a byte event shall load exp <= d+1 (mod 256), clear miss, clear gap and enter LOCK, with no err pulse.
REQ-018 In LOCK, a byte event with d==exp shall set exp <= exp+1 (mod 256), clear miss and clear gap.
REQ-019 In LOCK, a byte event with d!=exp shall pulse err, increment err_cnt, set miss <= miss+1, set exp <= exp+1 and clear gap.
REQ-020 In LOCK, when a mismatch brings miss to LOSS_THRESH, the block shall enter HUNT on the same edge, with that byte still counted as an error.
REQ-021 In LOCK, a clk_en tick without dv shall increment gap; when gap reaches GAP_MAX, to_err shall pulse, the block shall enter HUNT and gap shall be cleared.
REQ-022 If a byte event coincides with the tick that would reach GAP_MAX, the byte shall win: no timeout occurs and the byte is processed normally.
REQ-023 All outputs shall be registered and shall update on the edge that samples the byte event (one-clk latency from dv).
REQ-024 err and to_err shall be high for exactly one clk cycle per event and shall be 0 in any cycle following an edge with clk_en=0.
REQ-025 With clk_en=0, state, exp, miss, gap and the counters shall hold.
REQ-026 err_cnt shall saturate at 0xFFFF and not wrap.
REQ-027 clr=1 shall zero err_cnt (and byte_cnt) on the next edge regardless of clk_en; clr shall take priority over a simultaneous increment; clr shall not affect state or exp.

Reset
REQ-028 While n_rst=0, the block shall immediately set state=HUNT, lock=0, err=0, to_err=0, exp=0, miss=0, gap=0, err_cnt=0 and byte_cnt=0.
REQ-029 A reset asserted mid-stream shall discard lock, and the first byte after release shall re-seed per REQ-017.

Configuration
REQ-030 With macro PL_CHK_STATS_EN defined, byte_cnt shall be implemented as a 16-bit wrapping counter incremented on every byte event in either state and cleared by clr.
REQ-031 Without PL_CHK_STATS_EN, byte_cnt shall be tied to 0 and its counter logic omitted; all other behaviour is unchanged.

Verification
REQ-032 Scenario seed: bytes 0x10, 0x11 and 0x12 after reset shall give lock=1 after the first byte, no err pulse and err_cnt=0.
REQ-033 Scenario wrap: bytes 0xFE, 0xFF, 0x00 and 0x01 shall stay locked with no err pulse.
REQ-034 Scenario single slip: bytes 5, 6, 9, 8 with LOSS_THRESH=4 shall give one err pulse on 9, err_cnt=1, stay locked, and byte 8 shall match.
REQ-035 Scenario loss: four consecutive bad bytes shall give err_cnt=4 and lock=0 after the 4th; the next byte 0x40 shall re-seed, and 0x41 shall match.
REQ-036 Scenario timeout: while locked with GAP_MAX=40, 40 clk_en ticks without dv shall give one to_err pulse and lock=0; dv arriving on the 40th tick shall give no to_err.
REQ-037 Scenario counters: err_cnt preloaded to 0xFFFF plus a mismatch shall stay at 0xFFFF; clr together with a mismatch shall give err_cnt=0; with PL_CHK_STATS_EN, 3 bytes shall give byte_cnt=3.
